// File: rtl/ts_event_pack_buffer.sv
// Event build buffer: packs IN_W-bit words into RATIO-lane wide words, stores them in RAM and
// releases only whole committed events; events that overflow are rolled back atomically.
module ts_event_pack_buffer #(
  parameter int unsigned IN_W   = 32,
  parameter int unsigned RATIO  = 2,
  parameter int unsigned ADDR_W = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [IN_W-1:0]         in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IN_W*RATIO-1:0]   out_data,
  output logic [RATIO-1:0]        out_keep,
  output logic                    out_last,
  output logic [ADDR_W:0]         words_avail,
  output logic [15:0]             drop_count,
  output logic                    overflow
);

  localparam int unsigned DataW = IN_W * RATIO;
  localparam int unsigned LaneW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned MemW  = DataW + RATIO + 1;
  localparam int unsigned PtrW  = ADDR_W + 1;

  localparam logic [PtrW-1:0]  PtrOne   = PtrW'(1);
  localparam logic [PtrW-1:0]  PtrDepth = PtrW'(Depth);
  localparam logic [LaneW-1:0] LaneMax  = LaneW'(RATIO - 1);

  // Pack stage
  logic [LaneW-1:0] lane_q;
  logic [DataW-1:0] asm_data_q, asm_data_d;
  logic [RATIO-1:0] asm_keep_q, asm_keep_d;
  logic             pack_flush;

  // Flush register feeding the RAM write stage: {last, keep, data}
  logic             fl_valid_q;
  logic [MemW-1:0]  fl_word_q;
  logic             fl_last;

  // Write side
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  wr_commit_q, wr_commit_d;
  logic             dropping_q, dropping_d;
  logic [15:0]      drop_count_q, drop_count_d;
  logic [PtrW-1:0]  fill;
  logic             full, discard, do_write;

  // Read side
  logic [PtrW-1:0]  rd_ptr_q;
  logic             out_valid_q;
  logic [DataW-1:0] out_data_q;
  logic [RATIO-1:0] out_keep_q;
  logic             out_last_q;
  logic             fetch;

  logic [MemW-1:0]  mem [0:Depth-1];

  always_comb begin
    asm_data_d = asm_data_q;
    asm_keep_d = asm_keep_q;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (lane_q == LaneW'(k)) begin
        asm_data_d[k*IN_W +: IN_W] = in_data;
        asm_keep_d[k]              = 1'b1;
      end
    end
  end

  assign pack_flush = in_valid && (in_last || (lane_q == LaneMax));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q     <= '0;
      asm_data_q <= '0;
      asm_keep_q <= '0;
      fl_valid_q <= 1'b0;
      fl_word_q  <= '0;
    end else begin
      fl_valid_q <= pack_flush;
      if (pack_flush) begin
        fl_word_q  <= {in_last, asm_keep_d, asm_data_d};
        lane_q     <= '0;
        asm_data_q <= '0;
        asm_keep_q <= '0;
      end else if (in_valid) begin
        lane_q     <= lane_q + LaneW'(1);
        asm_data_q <= asm_data_d;
        asm_keep_q <= asm_keep_d;
      end
    end
  end

  assign fl_last = fl_word_q[MemW-1];

  // Full uses registered pointers only: a same-cycle read never makes room for this flush.
  assign fill     = wr_ptr_q - rd_ptr_q;
  assign full     = (fill == PtrDepth);
  assign discard  = fl_valid_q && (dropping_q || full);
  assign do_write = fl_valid_q && !discard;
  assign overflow = discard && fl_last;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    wr_commit_d  = wr_commit_q;
    dropping_d   = dropping_q;
    drop_count_d = drop_count_q;
    if (do_write) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
      if (fl_last) begin
        wr_commit_d = wr_ptr_q + PtrOne;
      end
    end else if (discard) begin
      if (fl_last) begin
        // Rolling back to the commit point also discards this event's earlier flushes.
        wr_ptr_d   = wr_commit_q;
        dropping_d = 1'b0;
        if (drop_count_q != 16'hFFFF) begin
          drop_count_d = drop_count_q + 16'd1;
        end
      end else begin
        dropping_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      wr_commit_q  <= '0;
      dropping_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      wr_commit_q  <= wr_commit_d;
      dropping_q   <= dropping_d;
      drop_count_q <= drop_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr_q[ADDR_W-1:0]] <= fl_word_q;
    end
  end

  assign fetch = (rd_ptr_q != wr_commit_q) && (!out_valid_q || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (fetch) begin
      {out_last_q, out_keep_q, out_data_q} <= mem[rd_ptr_q[ADDR_W-1:0]];
      rd_ptr_q    <= rd_ptr_q + PtrOne;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_keep    = out_keep_q;
  assign out_last    = out_last_q;
  assign words_avail = wr_commit_q - rd_ptr_q;
  assign drop_count  = drop_count_q;

endmodule
